// File: rtl/wb_pkg.sv
// Shared types for the elastic MEM->WB stage.
package wb_pkg;

    localparam int unsigned DATA_W_DEF = 16;
    localparam int unsigned ADDR_W_DEF = 4;

    // Occupancy of the two-slot skid buffer.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } wb_state_e;

    // Writeback payload at the default core widths.
    typedef struct packed {
        logic                  mem_to_reg;
        logic                  reg_write;
        logic [ADDR_W_DEF-1:0] dest_add;
        logic [DATA_W_DEF-1:0] mem_read_data;
        logic [DATA_W_DEF-1:0] alu_result;
    } wb_payload_t;

    // Flattened payload width for a given data/address width.
    function automatic int unsigned payload_width(input int unsigned data_w,
                                                  input int unsigned addr_w);
        return 2 + addr_w + 2 * data_w;
    endfunction

endpackage

// File: rtl/wb_stage_skid_if.sv
// MEM->WB handshake bus; master is the memory side / register file, slave is the stage.
interface wb_stage_skid_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 4
);
    logic              in_valid;
    logic              in_ready;
    logic              MemToRegM;
    logic              RegWriteM;
    logic [ADDR_W-1:0] destAddM;
    logic [DATA_W-1:0] MemReadDataM;
    logic [DATA_W-1:0] alu_resultM;

    logic              out_valid;
    logic              out_ready;
    logic              MemToRegW;
    logic              RegWriteW;
    logic [ADDR_W-1:0] destAddW;
    logic [DATA_W-1:0] MemReadDataW;
    logic [DATA_W-1:0] alu_resultW;
    logic [DATA_W-1:0] wb_data;

    modport master (
        output in_valid, MemToRegM, RegWriteM, destAddM, MemReadDataM, alu_resultM,
        output out_ready,
        input  in_ready,
        input  out_valid, MemToRegW, RegWriteW, destAddW, MemReadDataW, alu_resultW, wb_data
    );

    modport slave (
        input  in_valid, MemToRegM, RegWriteM, destAddM, MemReadDataM, alu_resultM,
        input  out_ready,
        output in_ready,
        output out_valid, MemToRegW, RegWriteW, destAddW, MemReadDataW, alu_resultW, wb_data
    );
endinterface

// File: rtl/wb_payload_reg.sv
// One payload slot: loadable register, cleared asynchronously by reset.
module wb_payload_reg #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] data_q;

    // Capture on load, otherwise hold.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_q <= '0;
        end else if (load_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/wb_stage_skid.sv
// Elastic MEM->WB stage: two-entry skid buffer, flush, gated writeback and forwarding hit.
module wb_stage_skid
    import wb_pkg::*;
#(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned ADDR_W   = 4,
    parameter bit          ZERO_REG = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic [ADDR_W-1:0] query_addr,
    output logic              fwd_hit,
    wb_stage_skid_if.slave    bus
);

    localparam int unsigned PAYLOAD_W = payload_width(DATA_W, ADDR_W);

    typedef struct packed {
        logic              mem_to_reg;
        logic              reg_write;
        logic [ADDR_W-1:0] dest_add;
        logic [DATA_W-1:0] mem_read_data;
        logic [DATA_W-1:0] alu_result;
    } slot_t;

    wb_state_e state_q;
    wb_state_e state_d;

    slot_t in_slot;
    slot_t main_d;
    slot_t main_q;
    slot_t skid_q;

    logic accept;
    logic pop;
    logic main_load;
    logic skid_load;
    logic main_from_skid;
    logic dest_ok;
    logic reg_write_w;

    assign in_slot = '{bus.MemToRegM, bus.RegWriteM, bus.destAddM,
                       bus.MemReadDataM, bus.alu_resultM};

    assign bus.in_ready  = (state_q != FULL);
    assign bus.out_valid = (state_q != EMPTY);
    assign accept        = bus.in_valid & bus.in_ready;
    assign pop           = bus.out_valid & bus.out_ready;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: flush dominates, otherwise track occupancy.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: if (accept) state_d = ONE;
                ONE: begin
                    if (accept && !pop) begin
                        state_d = FULL;
                    end else if (!accept && pop) begin
                        state_d = EMPTY;
                    end
                end
                FULL: if (pop) state_d = ONE;
                default: state_d = EMPTY;
            endcase
        end
    end

    // Slot load controls; a flush only clears valid state, payloads hold.
    always_comb begin
        main_load      = 1'b0;
        skid_load      = 1'b0;
        main_from_skid = 1'b0;
        if (!flush) begin
            case (state_q)
                EMPTY: main_load = accept;
                ONE: begin
                    main_load = accept & pop;
                    skid_load = accept & ~pop;
                end
                FULL: begin
                    main_load      = pop;
                    main_from_skid = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign main_d = main_from_skid ? skid_q : in_slot;

    wb_payload_reg #(.W(PAYLOAD_W)) u_main (
        .clk    (clk),
        .reset  (reset),
        .load_i (main_load),
        .d_i    (main_d),
        .q_o    (main_q)
    );

    wb_payload_reg #(.W(PAYLOAD_W)) u_skid (
        .clk    (clk),
        .reset  (reset),
        .load_i (skid_load),
        .d_i    (in_slot),
        .q_o    (skid_q)
    );

    // Stale or register-zero entries must never write or forward.
    assign dest_ok     = !ZERO_REG || (main_q.dest_add != '0);
    assign reg_write_w = main_q.reg_write & bus.out_valid & dest_ok;

    assign bus.MemToRegW    = main_q.mem_to_reg;
    assign bus.RegWriteW    = reg_write_w;
    assign bus.destAddW     = main_q.dest_add;
    assign bus.MemReadDataW = main_q.mem_read_data;
    assign bus.alu_resultW  = main_q.alu_result;
    assign bus.wb_data      = main_q.mem_to_reg ? main_q.mem_read_data : main_q.alu_result;
    assign fwd_hit          = reg_write_w && (main_q.dest_add == query_addr);

endmodule

// File: doc/wb_stage_skid.md
# wb_stage_skid

Parametrised, elastic MEM→WB pipeline stage for the CPU core. It replaces the fixed 16-bit free-running writeback register with a valid/ready handshake, a 2-entry skid buffer, synchronous flush, and a register-file-qualified writeback output. It also provides a forwarding-hit port for hazard logic. It sits between the memory stage and the register-file write port.

## Interface
- DATA_W, 16, width of MemReadData, alu_result, wb_data
- ADDR_W, 4, register address width
- ZERO_REG, 1, when 1, address 0 never writes and never forwards
- clk  in  1  clock
- reset  in  1  asynchronous, active-low
- flush  in  1  synchronous kill of all held entries
- in_valid  in  1  memory stage presents an instruction
- in_ready  out  1  stage can accept this cycle
- MemToRegM, RegWriteM  in  1 each  control bits
- destAddM  in  ADDR_W  destination register
- MemReadDataM, alu_resultM  in  DATA_W each  payload
- out_valid  out  1  WB entry valid
- out_ready  in  1  register file / downstream consumes entry
- MemToRegW  out  1  registered control
- RegWriteW  out  1  RegWrite & out_valid (& dest≠0 if ZERO_REG)
- destAddW  out  ADDR_W  registered destination
- MemReadDataW, alu_resultW  out  DATA_W  registered payload
- wb_data  out  DATA_W  MemToRegW ? MemReadDataW : alu_resultW
- query_addr  in  ADDR_W  hazard-unit source register
- fwd_hit  out  1  RegWriteW && destAddW==query_addr

## Operation
- Two slots: main (drives outputs) and skid. States are EMPTY, ONE (main valid), and FULL (main+skid valid).
- in_ready = (state != FULL). It is combinational from state only and never depends on out_ready.
- Accept = in_valid & in_ready. Pop = out_valid & out_ready.
- EMPTY: accept → main<=in, ONE.
- ONE: accept&pop → main<=in, stay ONE. Accept&!pop → skid<=in, FULL. !accept&pop → EMPTY. Otherwise hold.
- FULL: pop → main<=skid, ONE. No accept is possible.
- flush has the highest priority. It forces EMPTY next cycle and discards any in_valid in the same cycle. Payload registers hold their values; only the valid bits clear.
- RegWriteW and fwd_hit are forced 0 whenever out_valid=0, so stale payload never writes or forwards.
- With ZERO_REG=1 and destAddW=0, RegWriteW=0 and fwd_hit=0.
- wb_data and fwd_hit are combinational from the main slot and query_addr.

## Timing
- Reset (async assert, sync release): state EMPTY, out_valid=0, in_ready=1, all W outputs and payload 0, wb_data=0, fwd_hit=0.
- Latency: an input accepted in cycle N appears at the outputs with out_valid=1 in cycle N+1.
- Throughput is 1 per cycle while out_ready=1.
- Stall of one cycle (out_ready=0) while in_valid=1: the entry goes to skid and in_ready drops the next cycle.
- Order is strictly FIFO. No entry is lost or duplicated.
- out_valid=1 with out_ready=0: all W outputs stay stable until pop.
- Reset asserted mid-operation: both slots are invalidated immediately, regardless of clk.

## Structure
- Package wb_pkg: state enum (EMPTY, ONE, FULL); payload struct {MemToReg, RegWrite, destAdd[ADDR_W], MemReadData[DATA_W], alu_result[DATA_W]}; default widths 16/4.
- Sub-module wb_payload_reg: one payload slot with load enable and async clear. It is instantiated twice (main, skid).
- The top level holds the FSM, the handshake, the gating and the forwarding compare.

## Test plan
- Reset release, then in_valid=1 for one cycle (dest=3, alu=0x1234, RegWrite=1, MemToReg=0), out_ready=1. Required: next cycle out_valid=1, RegWriteW=1, wb_data=0x1234, destAddW=3; the cycle after, out_valid=0.
- Back-to-back stream of 8 entries with out_ready=0 for cycles 3–4. Required: in_ready=0 only while FULL, and the outputs deliver all 8 in order with no drop or duplicate.
- FULL state, then flush=1 with in_valid=1. Required: next cycle out_valid=0, RegWriteW=0, in_ready=1, and the flushed input never appears.
- Valid entry with dest=5, RegWrite=1. Required: query_addr=5 gives fwd_hit=1 and query_addr=6 gives 0. With ZERO_REG=1 and dest=0, RegWriteW=0 and fwd_hit=0 for query 0.
- MemToReg=1, MemReadData=0xBEEF, alu=0x0001. Required: wb_data=0xBEEF. Also assert reset mid-stream in FULL: all outputs 0 within the same cycle.
